pool_relu_2_by_2: RTL and testbench

- Downstream consumer of the 2x2 systolic array.
- Accumulates the four 8-bit conv results (c11,c12,c21,c22) over NUM_CH input-channel passes, each pass marked by a done_sa2 pulse.
- Then adds a signed bias, applies ReLU and saturation to 8 bits, and 2x2 max-pools to one output pixel.
- Result is presented on a valid/ready handshake to the next layer.

---
 rtl/pool_relu_pkg.sv | 9 +
 rtl/max4_8b.sv | 16 +
 rtl/pool_relu_2_by_2.sv | 85 ++++++++
 tb/tb_pool_relu_2_by_2.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/pool_relu_pkg.sv
// pool_relu_pkg: shared state encoding, constants and ReLU/saturation helper
package pool_relu_pkg;
  typedef enum logic [1:0] {ACCUM, ACT, POOL, OUT} state_t;
  localparam int DATA_W = 8;
  localparam int SAT_MAX = 255;
  function automatic logic [DATA_W-1:0] relu_sat(input logic signed [31:0] s);
    return s < 0 ? '0 : s > SAT_MAX ? DATA_W'(SAT_MAX) : s[DATA_W-1:0];
  endfunction
endpackage

// File: rtl/max4_8b.sv
// max4_8b: combinational unsigned maximum of four 8-bit values
module max4_8b (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] c,
  input  logic [7:0] d,
  output logic [7:0] y
);
  logic [7:0] m0, m1;
  // pairwise tree keeps the compare depth at two
  always_comb begin
    m0 = a > b ? a : b;
    m1 = c > d ? c : d;
    y = m0 > m1 ? m0 : m1;
  end
endmodule

// File: rtl/pool_relu_2_by_2.sv
// pool_relu_2_by_2: channel accumulation, bias + ReLU/saturation and 2x2 max-pool with valid/ready output
module pool_relu_2_by_2 import pool_relu_pkg::*; #(
  parameter int NUM_CH = 3,
  parameter int ACC_W = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       done_sa2,
  input  logic [7:0] c11,
  input  logic [7:0] c12,
  input  logic [7:0] c21,
  input  logic [7:0] c22,
  input  logic [7:0] bias,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] pool_out,
  output logic [7:0] act11,
  output logic [7:0] act12,
  output logic [7:0] act21,
  output logic [7:0] act22,
  output logic [3:0] ch_cnt,
  output logic       busy,
  output logic       err_drop
);
  if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_ch
    $error("NUM_CH must be in 1..16");
  end
  if (ACC_W < DATA_W + $clog2(NUM_CH)) begin : g_bad_acc
    $error("ACC_W too narrow for NUM_CH passes");
  end
  state_t state;
  logic [ACC_W-1:0] acc [4];
  logic [7:0] c_in [4];
  logic [7:0] act_r [4];
  logic [7:0] max_act;
  logic signed [ACC_W:0] s [4];
  assign c_in = '{c11, c12, c21, c22};
  assign act11 = act_r[0];
  assign act12 = act_r[1];
  assign act21 = act_r[2];
  assign act22 = act_r[3];
  assign busy = state != ACCUM;
  // accumulator plus sign-extended bias, one bit wider so the sum cannot wrap
  always_comb
    for (int i = 0; i < 4; i++)
      s[i] = $signed({1'b0, acc[i]}) + $signed({{(ACC_W-7){bias[7]}}, bias});
  max4_8b u_max (.a(act_r[0]), .b(act_r[1]), .c(act_r[2]), .d(act_r[3]), .y(max_act));
  // FSM with accumulators, activations and handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCUM;
      for (int i = 0; i < 4; i++) acc[i] <= '0;
      for (int i = 0; i < 4; i++) act_r[i] <= '0;
      ch_cnt <= '0;
      out_valid <= 1'b0;
      pool_out <= '0;
      err_drop <= 1'b0;
    end else begin
      if (done_sa2 && state != ACCUM) err_drop <= 1'b1;
      case (state)
        ACCUM: if (done_sa2) begin
          for (int i = 0; i < 4; i++) acc[i] <= acc[i] + ACC_W'(c_in[i]);
          ch_cnt <= ch_cnt + 4'd1;
          if (ch_cnt == 4'(NUM_CH - 1)) state <= ACT;
        end
        ACT: begin
          for (int i = 0; i < 4; i++) act_r[i] <= relu_sat(32'(s[i]));
          state <= POOL;
        end
        POOL: begin
          pool_out <= max_act;
          out_valid <= 1'b1;
          state <= OUT;
        end
        OUT: if (out_ready) begin
          out_valid <= 1'b0;
          for (int i = 0; i < 4; i++) acc[i] <= '0;
          ch_cnt <= '0;
          state <= ACCUM;
        end
        default: state <= ACCUM;
      endcase
    end
  end
endmodule

// File: tb/tb_pool_relu_2_by_2.sv
// tb_pool_relu_2_by_2: table-driven pixel vectors plus backpressure/drop and reset sequences
module tb_pool_relu_2_by_2;
  typedef struct packed {
    logic [4:0] nch;
    logic [3:0][7:0] c;
    logic signed [7:0] b;
    logic [3:0][7:0] e;
    logic [7:0] ep;
  } vec_t;
  logic clk = 0, rst = 0, done1 = 0, done3 = 0, out_ready = 0, use1 = 0;
  logic [7:0] c11 = 0, c12 = 0, c21 = 0, c22 = 0, bias = 0;
  logic o1_ov, o3_ov, o1_busy, o3_busy, o1_err, o3_err;
  logic [7:0] o1_pool, o3_pool, o1_a11, o1_a12, o1_a21, o1_a22, o3_a11, o3_a12, o3_a21, o3_a22;
  logic [3:0] o1_cc, o3_cc;
  logic ov, bsy, err;
  logic [7:0] pool, a11, a12, a21, a22;
  logic [3:0] cc;
  int checks = 0, errors = 0;
  vec_t vt [7];
  always #5 clk = ~clk;
  pool_relu_2_by_2 #(.NUM_CH(1), .ACC_W(12)) u1 (
    .clk(clk), .rst(rst), .done_sa2(done1), .c11(c11), .c12(c12), .c21(c21), .c22(c22),
    .bias(bias), .out_ready(out_ready), .out_valid(o1_ov), .pool_out(o1_pool),
    .act11(o1_a11), .act12(o1_a12), .act21(o1_a21), .act22(o1_a22),
    .ch_cnt(o1_cc), .busy(o1_busy), .err_drop(o1_err));
  pool_relu_2_by_2 #(.NUM_CH(3), .ACC_W(12)) u3 (
    .clk(clk), .rst(rst), .done_sa2(done3), .c11(c11), .c12(c12), .c21(c21), .c22(c22),
    .bias(bias), .out_ready(out_ready), .out_valid(o3_ov), .pool_out(o3_pool),
    .act11(o3_a11), .act12(o3_a12), .act21(o3_a21), .act22(o3_a22),
    .ch_cnt(o3_cc), .busy(o3_busy), .err_drop(o3_err));
  always_comb begin
    ov = use1 ? o1_ov : o3_ov;
    bsy = use1 ? o1_busy : o3_busy;
    err = use1 ? o1_err : o3_err;
    pool = use1 ? o1_pool : o3_pool;
    a11 = use1 ? o1_a11 : o3_a11;
    a12 = use1 ? o1_a12 : o3_a12;
    a21 = use1 ? o1_a21 : o3_a21;
    a22 = use1 ? o1_a22 : o3_a22;
    cc = use1 ? o1_cc : o3_cc;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask
  task automatic set_c(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    c11 = a; c12 = b; c21 = c; c22 = d;
  endtask
  task automatic pixel(input vec_t v, input int idx);
    use1 = v.nch == 1;
    set_c(v.c[3], v.c[2], v.c[1], v.c[0]);
    bias = v.b;
    out_ready = 1;
    for (int p = 0; p < int'(v.nch); p++) begin
      if (use1) done1 = 1; else done3 = 1;
      tick();
      done1 = 0; done3 = 0;
      if (p < int'(v.nch) - 1) begin
        chk($sformatf("v%0d_ch_cnt_p%0d", idx, p), 32'(cc), p + 1);
        chk($sformatf("v%0d_early_valid_p%0d", idx, p), 32'(ov), 0);
        repeat (4) tick();
      end
    end
    chk($sformatf("v%0d_busy_k1", idx), 32'(bsy), 1);
    chk($sformatf("v%0d_valid_k1", idx), 32'(ov), 0);
    tick();
    chk($sformatf("v%0d_valid_k2", idx), 32'(ov), 0);
    tick();
    chk($sformatf("v%0d_valid_k3", idx), 32'(ov), 1);
    chk($sformatf("v%0d_busy_k3", idx), 32'(bsy), 1);
    chk($sformatf("v%0d_act11", idx), 32'(a11), 32'(v.e[3]));
    chk($sformatf("v%0d_act12", idx), 32'(a12), 32'(v.e[2]));
    chk($sformatf("v%0d_act21", idx), 32'(a21), 32'(v.e[1]));
    chk($sformatf("v%0d_act22", idx), 32'(a22), 32'(v.e[0]));
    chk($sformatf("v%0d_pool", idx), 32'(pool), 32'(v.ep));
    tick();
    chk($sformatf("v%0d_valid_clear", idx), 32'(ov), 0);
    chk($sformatf("v%0d_busy_clear", idx), 32'(bsy), 0);
    chk($sformatf("v%0d_ch_cnt_clear", idx), 32'(cc), 0);
  endtask
  initial begin
    vt[0] = '{5'd1, {8'd15, 8'd16, 8'd6, 8'd15}, 8'sd0, {8'd15, 8'd16, 8'd6, 8'd15}, 8'd16};
    vt[1] = '{5'd1, {8'd15, 8'd16, 8'd6, 8'd15}, -8'sd10, {8'd5, 8'd6, 8'd0, 8'd5}, 8'd6};
    vt[2] = '{5'd3, {8'd15, 8'd16, 8'd6, 8'd15}, 8'sd0, {8'd45, 8'd48, 8'd18, 8'd45}, 8'd48};
    vt[3] = '{5'd3, {8'd200, 8'd200, 8'd200, 8'd200}, 8'sd100, {8'd255, 8'd255, 8'd255, 8'd255}, 8'd255};
    vt[4] = '{5'd3, {8'd1, 8'd2, 8'd3, 8'd4}, -8'sd5, {8'd0, 8'd1, 8'd4, 8'd7}, 8'd7};
    vt[5] = '{5'd1, {8'd255, 8'd0, 8'd128, 8'd127}, 8'sd127, {8'd255, 8'd127, 8'd255, 8'd254}, 8'd255};
    vt[6] = '{5'd3, {8'd50, 8'd43, 8'd42, 8'd0}, -8'sd128, {8'd22, 8'd1, 8'd0, 8'd0}, 8'd22};
    rst = 1;
    repeat (2) tick();
    rst = 0;
    for (int k = 0; k < 2; k++) begin
      use1 = k == 0;
      #0;
      chk($sformatf("rst%0d_valid", k), 32'(ov), 0);
      chk($sformatf("rst%0d_pool", k), 32'(pool), 0);
      chk($sformatf("rst%0d_act11", k), 32'(a11), 0);
      chk($sformatf("rst%0d_busy", k), 32'(bsy), 0);
      chk($sformatf("rst%0d_err", k), 32'(err), 0);
      chk($sformatf("rst%0d_ch_cnt", k), 32'(cc), 0);
    end
    for (int i = 0; i < 7; i++) pixel(vt[i], i);
    use1 = 0;
    out_ready = 0;
    bias = 0;
    set_c(10, 20, 30, 40);
    for (int p = 0; p < 3; p++) begin
      done3 = 1;
      tick();
      done3 = 0;
      if (p < 2) tick();
    end
    tick();
    tick();
    chk("bp_valid_start", 32'(ov), 1);
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin
        set_c(50, 50, 50, 50);
        done3 = 1;
      end
      tick();
      done3 = 0;
      chk($sformatf("bp_valid_hold%0d", i), 32'(ov), 1);
      chk($sformatf("bp_pool_hold%0d", i), 32'(pool), 120);
      chk($sformatf("bp_act11_hold%0d", i), 32'(a11), 30);
    end
    chk("bp_err_set", 32'(err), 1);
    out_ready = 1;
    tick();
    chk("bp_valid_clear", 32'(ov), 0);
    chk("bp_ch_cnt_clear", 32'(cc), 0);
    pixel('{5'd3, {8'd1, 8'd2, 8'd3, 8'd4}, 8'sd0, {8'd3, 8'd6, 8'd9, 8'd12}, 8'd12}, 10);
    chk("bp_err_sticky", 32'(err), 1);
    use1 = 0;
    set_c(9, 9, 9, 9);
    for (int p = 0; p < 2; p++) begin
      done3 = 1;
      tick();
      done3 = 0;
      tick();
    end
    chk("mid_ch_cnt", 32'(cc), 2);
    rst = 1;
    done3 = 1;
    tick();
    rst = 0;
    done3 = 0;
    chk("mr_err", 32'(err), 0);
    chk("mr_ch_cnt", 32'(cc), 0);
    chk("mr_pool", 32'(pool), 0);
    chk("mr_busy", 32'(bsy), 0);
    chk("mr_valid", 32'(ov), 0);
    pixel('{5'd3, {8'd1, 8'd2, 8'd3, 8'd4}, 8'sd0, {8'd3, 8'd6, 8'd9, 8'd12}, 8'd12}, 11);
    chk("mr_err_after", 32'(err), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
